// File: rtl/mem_controller_storeless_if.sv
// Load-side bus bundle for mem_controller_storeless: completion tokens,
// per-port load address/data channels and the BRAM read/write port pins.
interface mem_controller_storeless_if #(
    parameter int NUM_LOADS = 1,
    parameter int DATA_TYPE = 32,
    parameter int ADDR_TYPE = 32
);
    logic                           memStart_valid;
    logic                           memStart_ready;
    logic                           memEnd_valid;
    logic                           memEnd_ready;
    logic                           ctrlEnd_valid;
    logic                           ctrlEnd_ready;
    logic [NUM_LOADS*ADDR_TYPE-1:0] ldAddr;
    logic [NUM_LOADS-1:0]           ldAddr_valid;
    logic [NUM_LOADS-1:0]           ldAddr_ready;
    logic [NUM_LOADS*DATA_TYPE-1:0] ldData;
    logic [NUM_LOADS-1:0]           ldData_valid;
    logic [NUM_LOADS-1:0]           ldData_ready;
    logic [DATA_TYPE-1:0]           loadData;
    logic                           loadEn;
    logic [ADDR_TYPE-1:0]           loadAddr;
    logic                           storeEn;
    logic [ADDR_TYPE-1:0]           storeAddr;
    logic [DATA_TYPE-1:0]           storeData;

    // Controller side.
    modport slave (
        input  memStart_valid, memEnd_ready, ctrlEnd_valid,
        input  ldAddr, ldAddr_valid, ldData_ready, loadData,
        output memStart_ready, memEnd_valid, ctrlEnd_ready,
        output ldAddr_ready, ldData, ldData_valid,
        output loadEn, loadAddr, storeEn, storeAddr, storeData
    );

    // Requester / BRAM side.
    modport master (
        output memStart_valid, memEnd_ready, ctrlEnd_valid,
        output ldAddr, ldAddr_valid, ldData_ready, loadData,
        input  memStart_ready, memEnd_valid, ctrlEnd_ready,
        input  ldAddr_ready, ldData, ldData_valid,
        input  loadEn, loadAddr, storeEn, storeAddr, storeData
    );
endinterface

// File: rtl/mem_controller_storeless.sv
// Load-only memory controller: fixed-priority arbitration of NUM_LOADS
// load channels onto a 1-cycle-latency BRAM read port, per-port 2-entry
// response FIFOs, and the memStart/ctrlEnd/memEnd completion handshake.
// Ports: clk, rst (sync, active high), bus (slave modport of the _if).
module mem_controller_storeless #(
    parameter int NUM_LOADS = 1,
    parameter int DATA_TYPE = 32,
    parameter int ADDR_TYPE = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    mem_controller_storeless_if.slave   bus
);
    localparam int IDX_W = (NUM_LOADS > 1) ? $clog2(NUM_LOADS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t               state;
    logic                 start_ready;
    logic                 ctrl_ready;
    logic                 end_valid;

    logic [1:0]           count [NUM_LOADS];
    logic [DATA_TYPE-1:0] head  [NUM_LOADS];
    logic [DATA_TYPE-1:0] tail  [NUM_LOADS];
    logic                 inflight_v;
    logic [IDX_W-1:0]     inflight_idx;

    logic [NUM_LOADS-1:0] nonempty;
    logic [NUM_LOADS-1:0] drain;
    logic [NUM_LOADS-1:0] push;
    logic [NUM_LOADS-1:0] eligible;
    logic [NUM_LOADS-1:0] grant;
    logic [IDX_W-1:0]     grant_idx;
    logic [ADDR_TYPE-1:0] grant_addr;
    logic                 all_done;

    // Occupancy counts the slot already claimed by the read in flight and
    // frees the slot being drained this cycle, so a FIFO never overflows.
    always_comb begin
        nonempty = '0;
        drain    = '0;
        push     = '0;
        eligible = '0;
        for (int i = 0; i < NUM_LOADS; i++) begin
            nonempty[i] = (count[i] != 2'd0);
            drain[i]    = nonempty[i] & bus.ldData_ready[i];
            push[i]     = inflight_v && (inflight_idx == IDX_W'(i));
            eligible[i] = bus.ldAddr_valid[i] &&
                (({1'b0, count[i]} - {2'b0, drain[i]}
                  + {2'b0, push[i]}) < 3'd2);
        end
    end

    // Descending scan so the lowest eligible index wins.
    always_comb begin
        grant      = '0;
        grant_idx  = '0;
        grant_addr = '0;
        for (int i = NUM_LOADS - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                grant      = '0;
                grant[i]   = 1'b1;
                grant_idx  = IDX_W'(i);
                grant_addr = bus.ldAddr[i*ADDR_TYPE +: ADDR_TYPE];
            end
        end
    end

    always_comb begin
        bus.ldData = '0;
        for (int i = 0; i < NUM_LOADS; i++) begin
            bus.ldData[i*DATA_TYPE +: DATA_TYPE] = head[i];
        end
    end

    assign all_done = !inflight_v && !(|nonempty) && !(|bus.ldAddr_valid);

    assign bus.ldAddr_ready   = grant;
    assign bus.loadEn         = |grant;
    assign bus.loadAddr       = grant_addr;
    assign bus.ldData_valid   = nonempty;
    assign bus.storeEn        = 1'b0;
    assign bus.storeAddr      = '0;
    assign bus.storeData      = '0;
    assign bus.memStart_ready = start_ready;
    assign bus.ctrlEnd_ready  = ctrl_ready;
    assign bus.memEnd_valid   = end_valid;

    // Read pipeline and response FIFOs.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_v   <= 1'b0;
            inflight_idx <= '0;
            for (int i = 0; i < NUM_LOADS; i++) begin
                count[i] <= 2'd0;
                head[i]  <= '0;
                tail[i]  <= '0;
            end
        end else begin
            inflight_v <= |grant;
            if (|grant) begin
                inflight_idx <= grant_idx;
            end
            for (int i = 0; i < NUM_LOADS; i++) begin
                case ({push[i], drain[i]})
                    2'b10: begin
                        if (count[i] == 2'd0) begin
                            head[i] <= bus.loadData;
                        end else begin
                            tail[i] <= bus.loadData;
                        end
                        count[i] <= count[i] + 2'd1;
                    end
                    2'b01: begin
                        head[i]  <= tail[i];
                        count[i] <= count[i] - 2'd1;
                    end
                    2'b11: begin
                        if (count[i] == 2'd2) begin
                            head[i] <= tail[i];
                            tail[i] <= bus.loadData;
                        end else begin
                            head[i] <= bus.loadData;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Completion FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            start_ready <= 1'b1;
            ctrl_ready  <= 1'b0;
            end_valid   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.memStart_valid) begin
                    state       <= RUN;
                    start_ready <= 1'b0;
                    ctrl_ready  <= 1'b1;
                end
                RUN: if (bus.ctrlEnd_valid) begin
                    state      <= DRAIN;
                    ctrl_ready <= 1'b0;
                end
                DRAIN: if (all_done) begin
                    state     <= DONE;
                    end_valid <= 1'b1;
                end
                DONE: if (bus.memEnd_ready) begin
                    state       <= IDLE;
                    end_valid   <= 1'b0;
                    start_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_controller_storeless.sv
// Self-checking bench for mem_controller_storeless (NUM_LOADS=3): grant
// vector table, hand sequences for latency/backpressure/FSM/reset, and a
// per-port scoreboard of expected read data.
module tb_mem_controller_storeless;
    localparam int NL = 3;
    localparam int DW = 32;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_controller_storeless_if #(
        .NUM_LOADS(NL), .DATA_TYPE(DW), .ADDR_TYPE(AW)
    ) bus ();

    mem_controller_storeless #(
        .NUM_LOADS(NL), .DATA_TYPE(DW), .ADDR_TYPE(AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] q2[$];

    function automatic logic [31:0] bram_val(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    // BRAM read port model: one-cycle synchronous read.
    always @(posedge clk) begin
        if (bus.loadEn) bus.loadData <= bram_val(bus.loadAddr);
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int p, input logic [31:0] a);
        case (p)
            0: q0.push_back(bram_val(a));
            1: q1.push_back(bram_val(a));
            default: q2.push_back(bram_val(a));
        endcase
    endtask

    task automatic pop_chk(input int p, input logic [31:0] d);
        logic        have;
        logic [31:0] e;
        have = 1'b0;
        e    = '0;
        case (p)
            0: begin have = q0.size() > 0; if (have) e = q0.pop_front(); end
            1: begin have = q1.size() > 0; if (have) e = q1.pop_front(); end
            default: begin
                have = q2.size() > 0;
                if (have) e = q2.pop_front();
            end
        endcase
        compared++;
        if (!have) begin
            mismatched++;
            $display("FAIL data_p%0d: got %0h expected nothing", p, d);
        end else if (d !== e) begin
            mismatched++;
            $display("FAIL data_p%0d: got %0h expected %0h", p, d, e);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic set_addr(input int p, input logic [31:0] a);
        bus.ldAddr[p*AW +: AW] = a;
    endtask

    // Monitor: scoreboard pops, tied-off write port, FIFO overflow guard.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst !== 1'b1) begin
                for (int p = 0; p < NL; p++) begin
                    if (bus.ldData_valid[p] && bus.ldData_ready[p])
                        pop_chk(p, bus.ldData[p*DW +: DW]);
                    if (dut.inflight_v && dut.inflight_idx == 2'(p) &&
                        dut.count[p] == 2'd2 &&
                        !(bus.ldData_valid[p] && bus.ldData_ready[p])) begin
                        mismatched++;
                        $display("FAIL overflow_p%0d: push at count 2", p);
                    end
                end
                chk("store_tieoff",
                    {bus.storeEn, bus.storeAddr, bus.storeData[30:0]}, 64'd0);
            end
        end
    end

    typedef struct {
        logic [2:0]  valid;
        logic [31:0] a0, a1, a2;
        logic [2:0]  grant;
        logic [31:0] laddr;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{3'b001, 'h100, 'h200, 'h300, 3'b001, 'h100};
        vecs[1] = '{3'b101, 'h104, 'h204, 'h304, 3'b001, 'h104};
        vecs[2] = '{3'b100, 'h108, 'h208, 'h308, 3'b100, 'h308};
        vecs[3] = '{3'b110, 'h10C, 'h20C, 'h30C, 3'b010, 'h20C};
        vecs[4] = '{3'b111, 'h110, 'h210, 'h310, 3'b001, 'h110};
        vecs[5] = '{3'b000, 'h114, 'h214, 'h314, 3'b000, 'h0};
        vecs[6] = '{3'b010, 'h118, 'h218, 'h318, 3'b010, 'h218};
        vecs[7] = '{3'b011, 'h11C, 'h21C, 'h31C, 3'b001, 'h11C};

        rst                = 1'b1;
        bus.memStart_valid = 1'b0;
        bus.memEnd_ready   = 1'b0;
        bus.ctrlEnd_valid  = 1'b0;
        bus.ldAddr         = '0;
        bus.ldAddr_valid   = '0;
        bus.ldData_ready   = 3'b111;
        repeat (2) cyc();

        // Reset state
        rst = 1'b0;
        #1;
        chk("rst_memStart_ready", bus.memStart_ready, 1);
        chk("rst_ctrlEnd_ready", bus.ctrlEnd_ready, 0);
        chk("rst_memEnd_valid", bus.memEnd_valid, 0);
        chk("rst_loadEn", bus.loadEn, 0);
        chk("rst_ldAddr_ready", bus.ldAddr_ready, 0);
        chk("rst_ldData_valid", bus.ldData_valid, 0);

        // Single load with 2-cycle latency
        cyc();
        set_addr(0, 32'h10);
        bus.ldAddr_valid = 3'b001;
        #1;
        chk("single_grant", bus.ldAddr_ready, 3'b001);
        chk("single_loadEn", bus.loadEn, 1);
        chk("single_loadAddr", bus.loadAddr, 32'h10);
        push_exp(0, 32'h10);
        cyc();
        bus.ldAddr_valid = 3'b000;
        #1;
        chk("single_valid_t1", bus.ldData_valid[0], 0);
        cyc();
        #1;
        chk("single_valid_t2", bus.ldData_valid[0], 1);
        chk("single_data_t2", bus.ldData[31:0], 32'hDEADBEEF);
        repeat (2) cyc();

        // Grant vector table
        for (int k = 0; k < 8; k++) begin
            cyc();
            set_addr(0, vecs[k].a0);
            set_addr(1, vecs[k].a1);
            set_addr(2, vecs[k].a2);
            bus.ldAddr_valid = vecs[k].valid;
            #1;
            chk($sformatf("vec%0d_grant", k), bus.ldAddr_ready, vecs[k].grant);
            chk($sformatf("vec%0d_loadEn", k), bus.loadEn, |vecs[k].grant);
            chk($sformatf("vec%0d_loadAddr", k), bus.loadAddr, vecs[k].laddr);
            if (vecs[k].grant[0]) push_exp(0, vecs[k].a0);
            if (vecs[k].grant[1]) push_exp(1, vecs[k].a1);
            if (vecs[k].grant[2]) push_exp(2, vecs[k].a2);
        end
        cyc();
        bus.ldAddr_valid = '0;
        repeat (4) cyc();

        // Arbitration: ports 0 and 2 together
        cyc();
        set_addr(0, 32'h4);
        set_addr(2, 32'h8);
        bus.ldAddr_valid = 3'b101;
        #1;
        chk("arb_t0_grant", bus.ldAddr_ready, 3'b001);
        chk("arb_t0_addr", bus.loadAddr, 32'h4);
        push_exp(0, 32'h4);
        cyc();
        bus.ldAddr_valid = 3'b100;
        #1;
        chk("arb_t1_grant", bus.ldAddr_ready, 3'b100);
        chk("arb_t1_addr", bus.loadAddr, 32'h8);
        push_exp(2, 32'h8);
        cyc();
        bus.ldAddr_valid = 3'b000;
        #1;
        chk("arb_t2_valid", bus.ldData_valid, 3'b001);
        chk("arb_t2_data", bus.ldData[31:0], bram_val(32'h4));
        cyc();
        #1;
        chk("arb_t3_valid", bus.ldData_valid, 3'b100);
        chk("arb_t3_data", bus.ldData[95:64], bram_val(32'h8));
        repeat (3) cyc();

        // Backpressure on port 0
        cyc();
        bus.ldData_ready = 3'b110;
        set_addr(0, 32'h20);
        bus.ldAddr_valid = 3'b001;
        #1;
        chk("bp_req1", bus.ldAddr_ready[0], 1);
        push_exp(0, 32'h20);
        cyc();
        set_addr(0, 32'h21);
        #1;
        chk("bp_req2", bus.ldAddr_ready[0], 1);
        push_exp(0, 32'h21);
        cyc();
        set_addr(0, 32'h22);
        #1;
        chk("bp_block1", bus.ldAddr_ready[0], 0);
        cyc();
        #1;
        chk("bp_block2", bus.ldAddr_ready[0], 0);
        chk("bp_count2", dut.count[0], 2);
        chk("bp_head", bus.ldData[31:0], bram_val(32'h20));
        cyc();
        bus.ldData_ready = 3'b111;
        #1;
        chk("bp_req3", bus.ldAddr_ready[0], 1);
        push_exp(0, 32'h22);
        cyc();
        set_addr(0, 32'h23);
        #1;
        chk("bp_req4", bus.ldAddr_ready[0], 1);
        push_exp(0, 32'h23);
        cyc();
        bus.ldAddr_valid = 3'b000;
        repeat (5) cyc();

        // Full throughput on port 0
        for (int k = 0; k < 11; k++) begin
            cyc();
            if (k < 8) begin
                set_addr(0, 32'(k));
                bus.ldAddr_valid = 3'b001;
            end else begin
                bus.ldAddr_valid = 3'b000;
            end
            #1;
            chk($sformatf("tp%0d_grant", k), bus.ldAddr_ready[0], k < 8);
            chk($sformatf("tp%0d_valid", k), bus.ldData_valid[0],
                (k >= 2) && (k <= 9));
            if (k < 8) push_exp(0, 32'(k));
        end
        repeat (2) cyc();

        // Completion FSM with a load in flight at ctrlEnd
        cyc();
        bus.memStart_valid = 1'b1;
        #1;
        chk("fsm_start_ready", bus.memStart_ready, 1);
        cyc();
        bus.memStart_valid = 1'b0;
        bus.ldData_ready   = 3'b110;
        set_addr(0, 32'h30);
        bus.ldAddr_valid   = 3'b001;
        #1;
        chk("fsm_run_ctrl_ready", bus.ctrlEnd_ready, 1);
        chk("fsm_run_start_ready", bus.memStart_ready, 0);
        chk("fsm_load_grant", bus.ldAddr_ready, 3'b001);
        push_exp(0, 32'h30);
        cyc();
        bus.ldAddr_valid  = 3'b000;
        bus.ctrlEnd_valid = 1'b1;
        cyc();
        bus.ctrlEnd_valid = 1'b0;
        #1;
        chk("fsm_drain_ctrl_ready", bus.ctrlEnd_ready, 0);
        chk("fsm_drain_end0", bus.memEnd_valid, 0);
        chk("fsm_drain_data", bus.ldData_valid[0], 1);
        cyc();
        #1;
        chk("fsm_drain_end1", bus.memEnd_valid, 0);
        cyc();
        bus.ldData_ready = 3'b111;
        #1;
        chk("fsm_drain_end2", bus.memEnd_valid, 0);
        cyc();
        #1;
        chk("fsm_drain_end3", bus.memEnd_valid, 0);
        cyc();
        #1;
        chk("fsm_done_end", bus.memEnd_valid, 1);
        bus.memEnd_ready = 1'b1;
        cyc();
        bus.memEnd_ready = 1'b0;
        #1;
        chk("fsm_idle_start_ready", bus.memStart_ready, 1);
        chk("fsm_idle_end", bus.memEnd_valid, 0);

        // ctrlEnd and allRequestsDone in the same cycle
        cyc();
        bus.memStart_valid = 1'b1;
        cyc();
        bus.memStart_valid = 1'b0;
        bus.ctrlEnd_valid  = 1'b1;
        #1;
        chk("fsm2_ctrl_ready", bus.ctrlEnd_ready, 1);
        cyc();
        bus.ctrlEnd_valid = 1'b0;
        #1;
        chk("fsm2_drain_end", bus.memEnd_valid, 0);
        cyc();
        #1;
        chk("fsm2_done_end", bus.memEnd_valid, 1);
        bus.memEnd_ready = 1'b1;
        cyc();
        bus.memEnd_ready = 1'b0;
        #1;
        chk("fsm2_idle_start_ready", bus.memStart_ready, 1);

        // Reset mid-operation
        cyc();
        bus.memStart_valid = 1'b1;
        bus.ldData_ready   = 3'b110;
        set_addr(0, 32'h40);
        bus.ldAddr_valid   = 3'b001;
        #1;
        chk("rm_grant1", bus.ldAddr_ready, 3'b001);
        cyc();
        bus.memStart_valid = 1'b0;
        bus.ldAddr_valid   = 3'b000;
        #1;
        chk("rm_run", bus.memStart_ready, 0);
        cyc();
        set_addr(0, 32'h41);
        bus.ldAddr_valid = 3'b001;
        #1;
        chk("rm_count1_valid", bus.ldData_valid[0], 1);
        chk("rm_grant2", bus.ldAddr_ready, 3'b001);
        cyc();
        bus.ldAddr_valid = 3'b000;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("rm_ldData_valid", bus.ldData_valid, 0);
        chk("rm_loadEn", bus.loadEn, 0);
        chk("rm_start_ready", bus.memStart_ready, 1);
        cyc();
        #1;
        chk("rm_stale_valid", bus.ldData_valid, 0);
        chk("rm_stale_count", dut.count[0], 0);
        bus.ldData_ready = 3'b111;
        repeat (4) cyc();

        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);
        chk("q2_empty", q2.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
